// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Contents: FSM state encoding, word geometry, checksum width, address helper.
// Imported by imem_loader and imem_loader_byte_packer.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int CSUM_W         = 32;
    localparam int WC_W           = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_VER_RD   = 3'd3,
        ST_VER_WAIT = 3'd4,
        ST_RUN      = 3'd5,
        ST_ERR      = 3'd6
    } state_t;

    // Word index to byte address on the external memory port.
    function automatic logic [31:0] word_addr(input logic [WC_W-1:0] idx,
                                              input logic [31:0] step);
        return 32'(idx) * step;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory external port bundle for the loader.
// master: image source / memory side (drives bytes, returns rdata_ext).
// slave : the loader (accepts bytes, drives addr/wen/ren/wdata).
interface imem_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [31:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;

    modport master (
        output s_valid, s_data, s_last, rdata_ext,
        input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
    );

    modport slave (
        input  s_valid, s_data, s_last, rdata_ext,
        output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes big-endian into a word; first byte lands in the top lane, unfilled lanes stay 0.
// Latency: word_valid is combinational on the completing byte; the packed word is registered next cycle.
// Backpressure: none of its own; caller only presents bytes while it can accept them.
// Ports: clear (new load), byte_vld/byte_dat/byte_last (accepted byte), consume (word taken),
//        word_valid (this byte completes a word), word_last (held word carried s_last), word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              arst_n,
    input  logic              clear,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    input  logic              byte_last,
    input  logic              consume,
    output logic              word_valid,
    output logic              word_last,
    output logic [WORD_W-1:0] word
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] idx;

    assign word_valid = byte_vld && ((idx == IDX_W'(BYTES_PER_WORD - 1)) || byte_last);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            idx       <= '0;
            word      <= '0;
            word_last <= 1'b0;
        end else if (clear) begin
            idx       <= '0;
            word      <= '0;
            word_last <= 1'b0;
        end else begin
            // Zeroing on consume is what provides the padding of a short final word.
            if (consume) begin
                word      <= '0;
                word_last <= 1'b0;
            end
            if (byte_vld) begin
                for (int k = 0; k < BYTES_PER_WORD; k++) begin
                    if (idx == IDX_W'(k)) begin
                        word[WORD_W-1-8*k -: 8] <= byte_dat;
                    end
                end
                idx <= word_valid ? '0 : idx + 1'b1;
                if (word_valid) begin
                    word_last <= byte_last;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams an image into instruction memory, optionally verifies by readback sum, then enables the CPU.
// Latency: one WRITE cycle per packed word; verify costs (1 + RD_LAT) cycles per word; cpu_enable registered.
// Backpressure: s_ready only in LOAD, so the stream stalls during WRITE and after the image.
// Ports: clk/arst_n; start/halt/verify_en control; bus (byte stream + imem external port);
//        cpu_enable, busy, error, word_count status.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int ADDR_STEP  = 4,
    parameter int RD_LAT     = 1
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            start,
    input  logic            halt,
    input  logic            verify_en,
    imem_loader_if.slave    bus,
    output logic            cpu_enable,
    output logic            busy,
    output logic            error,
    output logic [WC_W-1:0] word_count
);

    localparam logic [31:0]     STEP    = 32'(ADDR_STEP);
    localparam logic [WC_W-1:0] CAP     = WC_W'(IMEM_WORDS);
    localparam logic [7:0]      LAT_END = 8'(RD_LAT - 1);

    state_t state, next_state;

    logic              verify_q;
    logic [CSUM_W-1:0] checksum;
    logic [CSUM_W-1:0] rd_sum;
    logic [WC_W-1:0]   rd_idx;
    logic [7:0]        lat_cnt;

    logic              start_ok;
    logic              byte_xfer;
    logic              at_cap;
    logic              rd_sample;
    logic              more_rd;
    logic              sum_ok;
    logic              pk_word_valid;
    logic              pk_word_last;
    logic [WORD_W-1:0] pk_word;

    assign start_ok  = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERR);
    assign byte_xfer = (state == ST_LOAD) && bus.s_valid;
    assign at_cap    = (word_count == CAP);
    assign rd_sample = (state == ST_VER_WAIT) && (lat_cnt == LAT_END);
    assign more_rd   = (rd_idx + 1'b1) < word_count;
    assign sum_ok    = (rd_sum + bus.rdata_ext) == checksum;

    // A byte arriving with memory already full is swallowed and flagged, never packed.
    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .arst_n     (arst_n),
        .clear      (start_ok),
        .byte_vld   (byte_xfer && !at_cap),
        .byte_dat   (bus.s_data),
        .byte_last  (bus.s_last),
        .consume    (state == ST_WRITE),
        .word_valid (pk_word_valid),
        .word_last  (pk_word_last),
        .word       (pk_word)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (start) next_state = ST_LOAD;
            ST_LOAD: begin
                if (byte_xfer) begin
                    if (at_cap)             next_state = ST_ERR;
                    else if (pk_word_valid) next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!pk_word_last) next_state = ST_LOAD;
                else if (verify_q) next_state = ST_VER_RD;
                else               next_state = ST_RUN;
            end
            ST_VER_RD:   next_state = ST_VER_WAIT;
            ST_VER_WAIT: begin
                if (rd_sample) begin
                    if (more_rd)     next_state = ST_VER_RD;
                    else if (sum_ok) next_state = ST_RUN;
                    else             next_state = ST_ERR;
                end
            end
            ST_RUN: begin
                if (start)     next_state = ST_LOAD;
                else if (halt) next_state = ST_IDLE;
            end
            ST_ERR:      if (start) next_state = ST_LOAD;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready   = 1'b0;
        bus.wen_ext   = 1'b0;
        bus.ren_ext   = 1'b0;
        bus.addr_ext  = '0;
        bus.wdata_ext = '0;
        busy          = 1'b0;
        error         = 1'b0;
        case (state)
            ST_LOAD: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
            end
            ST_WRITE: begin
                bus.wen_ext   = 1'b1;
                bus.addr_ext  = word_addr(word_count, STEP);
                bus.wdata_ext = pk_word;
                busy          = 1'b1;
            end
            ST_VER_RD: begin
                bus.ren_ext  = 1'b1;
                bus.addr_ext = word_addr(rd_idx, STEP);
                busy         = 1'b1;
            end
            ST_VER_WAIT: busy  = 1'b1;
            ST_ERR:      error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            word_count <= '0;
            checksum   <= '0;
            rd_sum     <= '0;
            rd_idx     <= '0;
            lat_cnt    <= '0;
            verify_q   <= 1'b0;
            cpu_enable <= 1'b0;
        end else begin
            // Enable follows the state being entered so it is high on the first RUN cycle.
            cpu_enable <= (next_state == ST_RUN);
            if (start_ok) begin
                word_count <= '0;
                checksum   <= '0;
                rd_sum     <= '0;
                rd_idx     <= '0;
                verify_q   <= verify_en;
            end else begin
                case (state)
                    ST_WRITE: begin
                        checksum   <= checksum + pk_word;
                        word_count <= word_count + 1'b1;
                    end
                    ST_VER_RD: lat_cnt <= '0;
                    ST_VER_WAIT: begin
                        if (rd_sample) begin
                            rd_sum <= rd_sum + bus.rdata_ext;
                            rd_idx <= rd_idx + 1'b1;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random byte streams, behavioural memory with optional corruption,
// and a scoreboard that matches every wen_ext/ren_ext pulse against an image-level model.
module tb_imem_loader;

    localparam int CAP_WORDS = 512;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic       verify_en = 1'b0;
    logic       cpu_enable;
    logic       busy;
    logic       error;
    logic [9:0] word_count;

    imem_loader_if bus();

    imem_loader #(.IMEM_WORDS(CAP_WORDS), .ADDR_STEP(4), .RD_LAT(1)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .halt       (halt),
        .verify_en  (verify_en),
        .bus        (bus),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [7:0]  img[$];
    logic [31:0] mem [0:CAP_WORDS-1];
    int          corrupt_idx = -1;
    wr_t         mon_e;
    logic [31:0] mon_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory with one-cycle read latency; a chosen word can be returned corrupted.
    always @(posedge clk) begin
        if (bus.wen_ext) mem[bus.addr_ext[10:2]] <= bus.wdata_ext;
        if (bus.ren_ext)
            bus.rdata_ext <= mem[bus.addr_ext[10:2]] ^
                ((int'(bus.addr_ext[10:2]) == corrupt_idx) ? 32'h0000_0100 : 32'h0);
    end

    // Scoreboard monitor: every memory-port pulse must match the head of its queue.
    always @(negedge clk) begin
        if (arst_n) begin
            if (bus.wen_ext || bus.ren_ext)
                chk("wen_ren_exclusive", 32'(bus.wen_ext & bus.ren_ext), 32'h0);
            if (bus.wen_ext) begin
                chk("s_ready_in_write", 32'(bus.s_ready), 32'h0);
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                             bus.addr_ext, bus.wdata_ext);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("write_addr", bus.addr_ext, mon_e.addr);
                    chk("write_data", bus.wdata_ext, mon_e.data);
                end
            end
            if (bus.ren_ext) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_read: addr 0x%08h, expected no read", bus.addr_ext);
                end else begin
                    mon_a = exp_rd.pop_front();
                    chk("read_addr", bus.addr_ext, mon_a);
                end
            end
        end
    end

    // Image-level model: big-endian words, zero padded, capped at memory size.
    task automatic expect_image(input bit ver, output bit exp_run, output logic [9:0] exp_wc);
        int  nb  = img.size();
        int  nw  = (nb + 3) / 4;
        bit  ovf = nb > 4 * CAP_WORDS;
        int  nwr = ovf ? CAP_WORDS : nw;
        wr_t e;
        for (int w = 0; w < nwr; w++) begin
            e.addr = 32'(w * 4);
            e.data = 32'h0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < nb) e.data = e.data | (32'(img[4*w+k]) << (24 - 8 * k));
            exp_wr.push_back(e);
        end
        if (ovf) begin
            exp_run = 1'b0;
            exp_wc  = 10'(CAP_WORDS);
        end else begin
            exp_wc  = 10'(nw);
            exp_run = 1'b1;
            if (ver) begin
                for (int w = 0; w < nw; w++) exp_rd.push_back(32'(w * 4));
                if (corrupt_idx >= 0 && corrupt_idx < nw) exp_run = 1'b0;
            end
        end
    endtask

    task automatic run_image(input bit ver, input int gap_pct, input int abort_after);
        bit         exp_run;
        logic [9:0] exp_wc;
        int         sent  = 0;
        int         stall = 0;
        bit         rdy;
        bit         done  = 1'b0;
        expect_image(ver, exp_run, exp_wc);
        @(posedge clk); #1;
        start     = 1'b1;
        verify_en = ver;
        @(posedge clk); #1;
        start     = 1'b0;
        verify_en = 1'($urandom_range(1));
        chk("start_to_load", 32'({busy, bus.s_ready, cpu_enable}), 32'b110);
        while (sent < img.size()) begin
            if (abort_after > 0 && sent == abort_after) break;
            if (int'($urandom_range(99)) < gap_pct) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'($urandom);
                bus.s_last  = 1'($urandom);
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = img[sent];
                bus.s_last  = (sent == img.size() - 1);
            end
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk); #1;
            if (bus.s_valid && rdy) begin
                sent++;
                stall = 0;
            end else begin
                stall++;
                if (stall > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_stall: byte %0d not accepted in 200 cycles, expected acceptance", sent);
                    break;
                end
            end
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (abort_after > 0) return;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("load_completes", 32'(done), 32'h1);
        chk("cpu_enable", 32'(cpu_enable), 32'(exp_run));
        chk("error", 32'(error), 32'(!exp_run));
        chk("word_count", 32'(word_count), 32'(exp_wc));
        chk("writes_drained", 32'(exp_wr.size()), 32'h0);
        chk("reads_drained", 32'(exp_rd.size()), 32'h0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"}, bus.addr_ext, 32'h0);
        chk({tag, "_wdata"}, bus.wdata_ext, 32'h0);
        chk({tag, "_flags"}, 32'({bus.s_ready, bus.wen_ext, bus.ren_ext, cpu_enable, busy, error}), 32'h0);
        chk({tag, "_word_count"}, 32'(word_count), 32'h0);
    endtask

    task automatic pulse_halt();
        @(posedge clk); #1;
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
    endtask

    task automatic set_img8();
        img.delete();
        for (int i = 0; i < 8; i++) img.push_back(8'(i * 8'h11));
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h0;
        bus.s_last  = 1'b0;
        #1;
        chk_outputs_zero("reset");
        #20 arst_n = 1'b1;

        // Two full words, no verify, then halt from RUN.
        set_img8();
        run_image(1'b0, 0, 0);
        pulse_halt();
        chk("halt_to_idle", 32'({cpu_enable, busy, error}), 32'h0);

        // Short final word padded with zeros.
        img.delete();
        for (int i = 0; i < 6; i++) img.push_back(8'(8'hAA + 8'(i * 8'h11)));
        run_image(1'b0, 0, 0);

        // Readback verify, clean then with word 1 corrupted.
        set_img8();
        run_image(1'b1, 0, 0);
        corrupt_idx = 1;
        run_image(1'b1, 0, 0);
        pulse_halt();
        chk("halt_ignored_in_err", 32'({error, cpu_enable}), 32'b10);
        corrupt_idx = -1;

        // Same image with random gaps on s_valid.
        set_img8();
        run_image(1'b0, 50, 0);

        // Random lengths, verify settings and gap densities.
        for (int t = 0; t < 6; t++) begin
            img.delete();
            for (int i = 0; i < int'($urandom_range(40, 1)); i++) img.push_back(8'($urandom));
            run_image(1'($urandom_range(1)), int'($urandom_range(60)), 0);
        end

        // One byte past capacity.
        img.delete();
        for (int i = 0; i < 4 * CAP_WORDS + 1; i++) img.push_back(8'($urandom));
        run_image(1'b0, 0, 0);

        // Reset in the middle of a load, then recover with a verified load.
        img.delete();
        for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
        run_image(1'b0, 30, 6);
        #2 arst_n = 1'b0;
        #1;
        chk_outputs_zero("midload_reset");
        exp_wr.delete();
        exp_rd.delete();
        #3 arst_n = 1'b1;
        set_img8();
        run_image(1'b1, 20, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1);
    end

endmodule
